// File: rtl/axi_wr_arbiter.sv
// Round-robin write-path arbiter: holds one grant across AW, W-through-WLAST and B.
// Optional watchdog abort is built when AXI_ARB_TIMEOUT_EN is defined.
module axi_wr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic                           aw_hs,
  input  logic                           w_last_hs,
  input  logic                           b_hs,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_idx,
  output logic                           busy,
  output logic                           timeout
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axi_wr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   busy_q, busy_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   sel_found_s;
  logic [IDX_W-1:0]       sel_idx_s;
  logic [IDX_W-1:0]       cand_s;
  logic                   release_s;
  logic                   expire_s;

  // Descending scan so the last hit kept is the nearest one above rr_ptr.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand_s = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (req[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    busy_d    = busy_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    release_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          grant_d   = NUM_MASTERS'(1'b1) << sel_idx_s;
          idx_d     = sel_idx_s;
          busy_d    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = XFER;
        end else begin
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      end
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end else begin
          state_d = XFER;
        end
      end
      RESP: begin
        if (b_hs) begin
          release_s = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A watchdog abort retires the grant exactly like a completed response.
    if (release_s || expire_s) begin
      grant_d   = '0;
      idx_d     = '0;
      busy_d    = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      rr_ptr_d  = idx_q;
      state_d   = IDLE;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= IDX_W'(NUM_MASTERS - 1);
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter sits at zero in IDLE, so it restarts on every new grant.
  always_comb begin
    cnt_d    = cnt_q;
    expire_s = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d    = cnt_q + 1'b1;
      expire_s = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
    timeout_d = expire_s & ~release_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model.
module tb_axi_wr_arbiter;

  localparam int N = 4;
`ifdef AXI_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         aw_hs = 1'b0;
  logic         w_last_hs = 1'b0;
  logic         b_hs = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  axi_wr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .aw_hs(aw_hs), .w_last_hs(w_last_hs),
    .b_hs(b_hs), .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = no owner, 1 = waiting for AW and WLAST, 2 = waiting for B.
  int       m_phase = 0;
  int       m_owner = 0;
  int       m_last  = N - 1;
  int       m_cnt   = 0;
  bit       m_aw = 1'b0, m_w = 1'b0, m_to = 1'b0, m_rel = 1'b0;
  int       m_c;
  logic [15:0] m_rq;
  logic [N-1:0] exp_grant;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
        m_aw = 1'b0; m_w = 1'b0; m_to = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_phase == 0) begin
          m_rq = 16'(req);
          for (int k = 1; k <= N; k++) begin
            m_c = (m_last + k) % N;
            if (m_rq[m_c[3:0]]) begin
              m_owner = m_c; m_phase = 1; m_aw = 1'b0; m_w = 1'b0; m_cnt = 0;
              break;
            end
          end
        end else begin
          m_rel = (m_phase == 2) && b_hs;
          if (m_phase == 1) begin
            m_aw = m_aw | aw_hs;
            m_w  = m_w | w_last_hs;
            if (m_aw && m_w) m_phase = 2;
          end
`ifdef AXI_ARB_TIMEOUT_EN
          m_cnt++;
          if (!m_rel && m_cnt == TO) begin
            m_to = 1'b1; m_rel = 1'b1;
          end
`endif
          if (m_rel) begin
            m_last = m_owner; m_phase = 0;
          end
        end
      end
      exp_grant = (m_phase != 0) ? N'(1 << m_owner) : '0;
      #2;
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("grant_idx", 32'(grant_idx), (m_phase != 0) ? 32'(m_owner) : 32'd0);
      chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
      chk("timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic step(input logic [N-1:0] r, input logic a, input logic w, input logic b);
    @(negedge clk);
    req = r; aw_hs = a; w_last_hs = w; b_hs = b;
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; aw_hs = 1'b0; w_last_hs = 1'b0; b_hs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // 1: single request from master 2, full transaction
    step(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("s1_grant", 32'(grant), 32'h4);
    chk("s1_idx", 32'(grant_idx), 32'd2);
    chk("s1_busy", 32'(busy), 32'd1);
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("s1_held_resp", 32'(grant), 32'h4);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s1_rel_grant", 32'(grant), 32'h0);
    chk("s1_rel_busy", 32'(busy), 32'h0);

    // 2: all requesting, rotation 0,1,2,3,0
    do_reset();
    for (int t = 0; t < 5; t++) begin
      step(4'b1111, 1'b0, 1'b0, 1'b0);
      chk("s2_rr_idx", 32'(grant_idx), 32'(t % 4));
      step(4'b1111, 1'b1, 1'b1, 1'b0);
      step(4'b1111, 1'b0, 1'b0, 1'b1);
      chk("s2_gap", 32'(grant), 32'h0);
    end

    // 3: stray b_hs in XFER, then AW and WLAST together
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s3_stray_b", 32'(grant), 32'h1);
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s3_resp_rel", 32'(busy), 32'h0);

    // 4: WLAST two cycles before AW, req dropped mid-XFER
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("s4_grant", 32'(grant), 32'h8);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s4_sticky", 32'(grant), 32'h8);
    step(4'b0000, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s4_rel", 32'(grant), 32'h0);

    // 5: asynchronous reset while in RESP
    do_reset();
    step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("s5_resp_grant", 32'(grant), 32'h2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("s5_async_grant", 32'(grant), 32'h0);
    chk("s5_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(4'b0011, 1'b0, 1'b0, 1'b0);
    chk("s5_after_grant", 32'(grant), 32'h1);
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);

`ifdef AXI_ARB_TIMEOUT_EN
    // 6a: no handshakes, watchdog fires 8 cycles after grant
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t < 8; t++) step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("s6_pre_to", 32'(timeout), 32'h0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("s6_to_pulse", 32'(timeout), 32'h1);
    chk("s6_to_grant", 32'(grant), 32'h0);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("s6_to_end", 32'(timeout), 32'h0);
    // 6b: b_hs in the expiry cycle wins
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b1, 1'b0);
    for (int t = 2; t < 8; t++) step(4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("s6_b_wins", 32'(timeout), 32'h0);
    chk("s6_b_grant", 32'(grant), 32'h0);
`endif

    // Randomized traffic; the per-cycle compare process checks every step.
    for (int t = 0; t < 3000; t++) begin
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    step(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin write-path arbiter for the AXI interconnect.
- Shares one downstream master port (m_axi_aw*/w*/b*) among NUM_MASTERS upstream slave ports.
- Grants one requester and holds that grant for a full write transaction: AW handshake, W through WLAST, then B handshake.
- Outputs steer the interconnect's AW/W/B muxes. The arbiter carries no payload.

Parameters:
- NUM_MASTERS, 4: number of requesting upstream ports, 2..16.
- IDX_W, $clog2(NUM_MASTERS): width of the encoded grant index. Derived localparam, not overridable.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles. Used only with AXI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_MASTERS  per-master request; bit i = s_axi_awvalid of port i.
- aw_hs  in  1  m_axi_awvalid & m_axi_awready on the downstream port.
- w_last_hs  in  1  m_axi_wvalid & m_axi_wready & m_axi_wlast downstream.
- b_hs  in  1  m_axi_bvalid & m_axi_bready downstream.
- grant  out  NUM_MASTERS  one-hot grant, registered.
- grant_idx  out  IDX_W  binary index of the granted master, registered.
- busy  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when the watchdog aborts a grant.

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - State=IDLE, rr_ptr=NUM_MASTERS-1, so master 0 wins first. aw_done=0, w_done=0.
  - Reset asserted mid-transaction drops the grant immediately with no completion. The interconnect drains separately.
- States: IDLE, XFER, RESP.
- IDLE:
  - If req is nonzero, select the first set bit searching upward from rr_ptr+1 with wrap modulo NUM_MASTERS.
  - Register grant/grant_idx, set busy=1, go to XFER. Latency from req to grant is 1 cycle.
  - If req=0, stay in IDLE with grant=0.
- XFER:
  - aw_hs sets aw_done. w_last_hs sets w_done. W may complete before, with, or after AW.
  - When aw_done and w_done are both set (including both events arriving in the same cycle), go to RESP next cycle.
  - aw_hs or w_last_hs arriving a second time are ignored.
- RESP:
  - On b_hs: clear grant, busy, aw_done and w_done; set rr_ptr=grant_idx; go to IDLE.
  - New arbitration happens in IDLE, so there is at least 1 idle cycle between grants.
- Any b_hs seen outside RESP is ignored.
- Grant is sticky: req deasserting while busy does not release the grant.
- Fairness: a master that has just completed has the lowest priority in the next arbitration. With all masters requesting continuously, grants cycle 0,1,2,3,0,...
- grant is always one-hot or zero. grant_idx is 0 whenever grant=0.

Optional Feature:
- Macro AXI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits resets to 0 on every grant and increments each cycle in XFER or RESP.
  - When it reaches TIMEOUT_CYCLES: pulse timeout for 1 cycle, release the grant as if b_hs occurred (rr_ptr updated), and go to IDLE.
  - b_hs in the same cycle as the expiry takes priority, so no timeout pulse is issued.
- Without the macro: no counter is built, timeout is tied to 0, and the grant is held indefinitely.

Test Plan (all scenarios use NUM_MASTERS=4):
1. Reset, then req=4'b0100 -> 1 cycle later grant=4'b0100, grant_idx=2, busy=1. Then aw_hs, w_last_hs 3 cycles later, b_hs 2 cycles after that -> grant=0, busy=0 the cycle after b_hs.
2. req=4'b1111 held for 4 transactions -> grant_idx sequence 0,1,2,3. The 5th transaction grants 0.
3. aw_hs and w_last_hs in the same cycle -> RESP entered next cycle. A b_hs pulsed during XFER before this is ignored, and grant is still held.
4. w_last_hs 2 cycles before aw_hs -> transition to RESP only after aw_hs. req drops to 0 mid-XFER -> grant unchanged.
5. Assert reset while in RESP with grant=4'b0010 -> grant=0, busy=0 without waiting for a clock edge. After release, req=4'b0011 -> grant 0.
6. With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant, then no aw_hs -> timeout pulses 1 cycle, 8 cycles after the grant, and grant clears. A second case with b_hs in the expiry cycle -> no timeout pulse.
